reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_mp.sv | 93 +++++++++
 tb/tb_reg_file_mp.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-port register file: two write ports, two synchronous read ports with write bypass,
// and a busy scoreboard that reservations set and writes clear.
module reg_file_mp #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int ZERO_R0 = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic                     re,
    input  logic [ADDR_W-1:0]        ra0,
    input  logic [ADDR_W-1:0]        ra1,
    output logic [DATA_W-1:0]        rd0,
    output logic [DATA_W-1:0]        rd1,
    output logic                     rd0_busy,
    output logic                     rd1_busy,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [(1<<ADDR_W)-1:0]   busy_vec
);

    localparam int NREGS = 1 << ADDR_W;

    logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NREGS-1:0]             busy_q, busy_d;
    logic [DATA_W-1:0]            rd0_q, rd0_d, rd1_q, rd1_d;
    logic                         rd0_busy_q, rd0_busy_d, rd1_busy_q, rd1_busy_d;

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        // Port 1 is applied last so it wins on a same-address double write.
        if (we0) begin
            regs_d[wa0] = wd0;
            busy_d[wa0] = 1'b0;
        end
        if (we1) begin
            regs_d[wa1] = wd1;
            busy_d[wa1] = 1'b0;
        end
        // Reservation after clears: a new producer overrides a retiring one.
        if (rsv_en) begin
            busy_d[rsv_addr] = 1'b1;
        end
        if (ZERO_R0 != 0) begin
            regs_d[0] = '0;
            busy_d[0] = 1'b0;
        end

        // Reading the next-state arrays gives the write bypass and post-update busy for free.
        rd0_d      = rd0_q;
        rd1_d      = rd1_q;
        rd0_busy_d = rd0_busy_q;
        rd1_busy_d = rd1_busy_q;
        if (re) begin
            rd0_d      = regs_d[ra0];
            rd1_d      = regs_d[ra1];
            rd0_busy_d = busy_d[ra0];
            rd1_busy_d = busy_d[ra1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q     <= '0;
            busy_q     <= '0;
            rd0_q      <= '0;
            rd1_q      <= '0;
            rd0_busy_q <= 1'b0;
            rd1_busy_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            rd0_q      <= rd0_d;
            rd1_q      <= rd1_d;
            rd0_busy_q <= rd0_busy_d;
            rd1_busy_q <= rd1_busy_d;
        end
    end

    assign rd0      = rd0_q;
    assign rd1      = rd1_q;
    assign rd0_busy = rd0_busy_q;
    assign rd1_busy = rd1_busy_q;
    assign busy_vec = busy_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp; a second instance covers the
// hardwired-zero register 0 variant with the same stimulus.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we0, we1, re, rsv_en;
    logic [2:0]  wa0, wa1, ra0, ra1, rsv_addr;
    logic [15:0] wd0, wd1;

    logic [15:0] rd0, rd1, z_rd0, z_rd1;
    logic        rd0_busy, rd1_busy, z_rd0_busy, z_rd1_busy;
    logic [7:0]  busy_vec, z_busy_vec;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_mp #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .re(re), .ra0(ra0), .ra1(ra1),
        .rd0(rd0), .rd1(rd1), .rd0_busy(rd0_busy), .rd1_busy(rd1_busy),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec)
    );

    reg_file_mp #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(1)) dut_z (
        .clk(clk), .rst_n(rst_n),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .re(re), .ra0(ra0), .ra1(ra1),
        .rd0(z_rd0), .rd1(z_rd1), .rd0_busy(z_rd0_busy), .rd1_busy(z_rd1_busy),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(z_busy_vec)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; rsv_en = 0; re = 0;
        wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0;
        ra0 = 0; ra1 = 0; rsv_addr = 0;
    endtask

    initial begin
        idle();
        rst_n = 0;
        step();
        step();
        chk("reset_rd0", rd0, 0);
        chk("reset_rd1", rd1, 0);
        chk("reset_busy", busy_vec, 0);
        rst_n = 1;

        re = 1; ra0 = 5; ra1 = 7;
        step();
        chk("r27_rd0", rd0, 16'h0000);
        chk("r27_rd1", rd1, 16'h0000);
        chk("r27_busy", busy_vec, 8'h00);

        we0 = 1; wa0 = 3; wd0 = 16'hBEEF; ra0 = 3;
        step();
        chk("bypass_rd0", rd0, 16'hBEEF);
        we0 = 0;
        step();
        chk("reread_rd0", rd0, 16'hBEEF);

        re = 0; ra0 = 5;
        step();
        chk("hold_rd0", rd0, 16'hBEEF);

        we0 = 1; wa0 = 2; wd0 = 16'h1111;
        we1 = 1; wa1 = 2; wd1 = 16'h2222;
        step();
        we0 = 0; we1 = 0; re = 1; ra0 = 2;
        step();
        chk("dual_same_addr", rd0, 16'h2222);

        we0 = 1; wa0 = 6; wd0 = 16'hAAAA;
        we1 = 1; wa1 = 6; wd1 = 16'h5555; ra1 = 6;
        step();
        chk("bypass_double", rd1, 16'h5555);

        wa0 = 1; wd0 = 16'h0101; wa1 = 7; wd1 = 16'h0707; re = 0;
        step();
        we0 = 0; we1 = 0; re = 1; ra0 = 1; ra1 = 7;
        step();
        chk("dual_rd0", rd0, 16'h0101);
        chk("dual_rd1", rd1, 16'h0707);

        rsv_en = 1; rsv_addr = 4; ra0 = 4;
        step();
        chk("rsv_busy", busy_vec, 8'h10);
        chk("rsv_rd0_busy", rd0_busy, 1);
        rsv_en = 0; we1 = 1; wa1 = 4; wd1 = 16'h4444;
        step();
        chk("clr_busy", busy_vec, 8'h00);
        chk("clr_rd0_busy", rd0_busy, 0);
        chk("clr_rd0", rd0, 16'h4444);
        rsv_en = 1; rsv_addr = 4; wd1 = 16'h4848;
        step();
        chk("rsvwr_busy", busy_vec, 8'h10);
        chk("rsvwr_rd0_busy", rd0_busy, 1);
        chk("rsvwr_rd0", rd0, 16'h4848);

        we1 = 0;
        we0 = 1; wa0 = 0; wd0 = 16'hFFFF; rsv_en = 1; rsv_addr = 0; ra1 = 0;
        step();
        chk("z_rd1", z_rd1, 16'h0000);
        chk("z_rd1_busy", z_rd1_busy, 0);
        chk("z_busy", z_busy_vec, 8'h10);
        chk("nz_rd1", rd1, 16'hFFFF);
        chk("nz_rd1_busy", rd1_busy, 1);
        chk("nz_busy", busy_vec, 8'h11);
        we0 = 0; rsv_en = 0;
        step();
        chk("z_reread", z_rd1, 16'h0000);
        chk("nz_reread", rd1, 16'hFFFF);

        re = 0;
        for (int i = 1; i < 8; i++) begin
            we0 = 1; wa0 = 3'(i); wd0 = 16'(16'h1000 + i * 16'h0111);
            step();
        end
        we0 = 0; re = 1; ra0 = 5; ra1 = 7;
        step();
        chk("pre_rst_rd0", rd0, 16'h1555);
        chk("pre_rst_rd1", rd1, 16'h1777);

        rst_n = 0; we0 = 1; wa0 = 5; wd0 = 16'h5A5A; rsv_en = 1; rsv_addr = 6;
        step();
        chk("rst_rd0", rd0, 0);
        chk("rst_busy", busy_vec, 0);
        rst_n = 1; we0 = 0; rsv_en = 0;
        for (int i = 0; i < 8; i++) begin
            ra0 = 3'(i); ra1 = 3'(7 - i);
            step();
            chk("post_rst_rd0", rd0, 0);
            chk("post_rst_rd1", rd1, 0);
        end
        chk("post_rst_busy", busy_vec, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
